// File: rtl/ahci_dma_rd_pack_pkg.sv
// Shared definitions for the AHCI DMA read-path lane packer.
//   flush_state_e : flush FSM states (idle / draining a partial word)
//   clog2         : ceiling log2 for sizing lane counters
//   lane_mask     : low-contiguous mask with n ones, used for partial-word dout_dm
package ahci_dma_rd_pack_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    function automatic int clog2(input int unsigned v);
        int          r = 0;
        int unsigned p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

    function automatic logic [31:0] lane_mask(input int unsigned n);
        if (n >= 32) return '1;
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/ahci_dma_rd_pack_lane_compact.sv
// Combinational lane compactor.
//   din   : input word, lane i = din[i*LANE_W +: LANE_W]
//   dm    : lane valid mask, any pattern including all zeros
//   lanes : valid lanes moved down to positions 0..k-1 in ascending order,
//           all lanes above k are zero
//   k     : number of valid lanes (popcount of dm)
module ahci_dma_lane_compact #(
    parameter int LANES  = 2,
    parameter int LANE_W = 16,
    parameter int CNT_W  = 2
) (
    input  logic [LANES*LANE_W-1:0] din,
    input  logic [LANES-1:0]        dm,
    output logic [LANES*LANE_W-1:0] lanes,
    output logic [CNT_W-1:0]        k
);

    logic [CNT_W-1:0] cnt;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lanes = '0;
        cnt   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (dm[i]) begin
                lanes[cnt*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
                cnt = cnt + CNT_W'(1);
            end
        end
        k = cnt;
    end

endmodule

// File: rtl/ahci_dma_rd_pack.sv
// Lane packer on the AHCI DMA read path: compacts masked input words into
// continuous full-width output words, lowest lane first, with a partial-word flush.
//   clk, rst            : clock, synchronous active-high reset
//   din_av / din_avm    : one / more than one word available in the 1-latency read FIFO
//   din, dm             : input word and its lane valid mask
//   din_re              : consume current din (combinational)
//   flush               : single-cycle request to emit any partial word
//   dout, dout_dm       : packed output word and its valid lanes
//   dout_vld / dout_re  : output valid / consumer take
//   flush_done          : 1-cycle pulse when a flush has completed
module ahci_dma_rd_pack
    import ahci_dma_rd_pack_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int LANE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_av,
    input  logic                    din_avm,
    input  logic [LANES*LANE_W-1:0] din,
    input  logic [LANES-1:0]        dm,
    output logic                    din_re,
    input  logic                    flush,
    output logic [LANES*LANE_W-1:0] dout,
    output logic [LANES-1:0]        dout_dm,
    output logic                    dout_vld,
    input  logic                    dout_re,
    output logic                    flush_done
);

    localparam int DW = LANES * LANE_W;
    // Wide enough for acc_cnt + k, which peaks at 2*LANES-1.
    localparam int CNT_W = clog2(LANES) + 1;

    logic [DW-1:0]    comp;
    logic [CNT_W-1:0] k;
    logic [DW-1:0]    acc;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] total;
    logic [2*DW-1:0]  merged;
    logic [31:0]      flush_mask;
    logic             din_re_d;
    logic             slot_free;
    logic             din_safe;
    logic             full;
    logic             flush_ok;
    logic             load_full;
    logic             load_flush;
    flush_state_e     state;

    ahci_dma_lane_compact #(
        .LANES (LANES),
        .LANE_W(LANE_W),
        .CNT_W (CNT_W)
    ) u_compact (
        .din  (din),
        .dm   (dm),
        .lanes(comp),
        .k    (k)
    );

    assign total     = acc_cnt + k;
    assign full      = (total >= CNT_W'(LANES));
    assign slot_free = !dout_vld | dout_re;
    // The FIFO needs a cycle to present the next word after a read, so with only
    // one word available we must not read on two consecutive cycles.
    assign din_safe  = din_av & (din_avm | !din_re_d);
    assign din_re    = din_safe & ((k == '0) | !full | slot_free);

    // acc lanes above acc_cnt are always zero, so OR-ing in the shifted compacted
    // lanes yields acc followed by the new lanes across a double-width window.
    assign merged = {{DW{1'b0}}, acc} | ({{DW{1'b0}}, comp} << (int'(acc_cnt) * LANE_W));

    assign flush_ok   = (state == ST_FLUSH) & !din_re & slot_free;
    assign load_full  = din_re & full;
    assign load_flush = flush_ok & (acc_cnt != '0);
    assign flush_mask = lane_mask(int'(acc_cnt));

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            acc_cnt    <= '0;
            din_re_d   <= 1'b0;
            dout       <= '0;
            dout_dm    <= '0;
            dout_vld   <= 1'b0;
            flush_done <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            din_re_d   <= din_re;
            flush_done <= flush_ok;

            if (din_re) begin
                if (full) begin
                    acc     <= merged[2*DW-1:DW];
                    acc_cnt <= total - CNT_W'(LANES);
                end else begin
                    acc     <= merged[DW-1:0];
                    acc_cnt <= total;
                end
            end else if (load_flush) begin
                acc     <= '0;
                acc_cnt <= '0;
            end

            if (load_full) begin
                dout     <= merged[DW-1:0];
                dout_dm  <= '1;
                dout_vld <= 1'b1;
            end else if (load_flush) begin
                dout     <= acc;
                dout_dm  <= flush_mask[LANES-1:0];
                dout_vld <= 1'b1;
            end else if (dout_re & dout_vld) begin
                dout_vld <= 1'b0;
            end

            if (state == ST_IDLE) begin
                if (flush) state <= ST_FLUSH;
            end else if (flush_ok) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule
